// File: rtl/demux_scan_sequencer.sv
// Scan sequencer for a 1-to-16 demux: walks the select, blanks between channels and
// drives each channel's frame bit for a fixed dwell. Frames arrive double-buffered.
module demux_scan_sequencer #(
   parameter int unsigned CLK_DIV      = 50000,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] frame_data,
   output logic [3:0]  sel_out,
   output logic        data_out,
   output logic        frame_done,
   output logic        busy
);

   localparam int unsigned MAX_CNT   = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
   localparam int unsigned CNT_W     = $clog2(MAX_CNT + 1);
   localparam int unsigned BLANK_END = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_END);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_e;

   // Every channel starts in BLANK unless blanking is disabled.
   localparam state_e FIRST_ST = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

   state_e           state, nxt_state;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic [15:0]      active, nxt_active;
   logic [15:0]      shadow, nxt_shadow;
   logic             pending, nxt_pending;
   logic [3:0]       nxt_sel;
   logic             nxt_data, nxt_frame_done, nxt_busy;
   logic             swap, transfer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         active     <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         load_ready <= 1'b1;
         sel_out    <= '0;
         data_out   <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= nxt_state;
         cnt        <= nxt_cnt;
         active     <= nxt_active;
         shadow     <= nxt_shadow;
         pending    <= nxt_pending;
         load_ready <= ~nxt_pending;
         sel_out    <= nxt_sel;
         data_out   <= nxt_data;
         frame_done <= nxt_frame_done;
         busy       <= nxt_busy;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_sel   = sel_out;
      swap      = 1'b0;

      case (state)
         IDLE: begin
            nxt_sel = 4'd0;
            if (enable) begin
               nxt_state = FIRST_ST;
               nxt_cnt   = '0;
               swap      = 1'b1;
            end
         end
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               nxt_state = DRIVE;
               nxt_cnt   = '0;
            end else begin
               nxt_cnt = cnt + CNT_W'(1);
            end
         end
         DRIVE: begin
            if (cnt == DRIVE_LAST) begin
               nxt_cnt = '0;
               if (sel_out == 4'd15) begin
                  nxt_sel = 4'd0;
                  swap    = 1'b1;
               end else begin
                  nxt_sel = sel_out + 4'd1;
               end
               // A dropped enable is only honoured once the dwell has completed.
               if (enable) begin
                  nxt_state = FIRST_ST;
               end else begin
                  nxt_state = IDLE;
                  nxt_sel   = 4'd0;
               end
            end else begin
               nxt_cnt = cnt + CNT_W'(1);
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
            nxt_sel   = 4'd0;
         end
      endcase

      // Shadow accepts only while empty, so a swap and a transfer never collide on pending.
      transfer    = load_valid & ~pending;
      nxt_active  = (swap && pending) ? shadow : active;
      nxt_shadow  = transfer ? frame_data : shadow;
      nxt_pending = transfer ? 1'b1 : (swap ? 1'b0 : pending);

      // Demux asserts out[15-sel]; ~sel is 15-sel for a 4-bit select.
      nxt_data       = (nxt_state == DRIVE) & nxt_active[~nxt_sel];
      nxt_frame_done = (nxt_state == DRIVE) && (nxt_cnt == DRIVE_LAST) && (nxt_sel == 4'd15);
      nxt_busy       = (nxt_state != IDLE);
   end

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// Directed bench for demux_scan_sequencer: one instance with dwell 4 / blank 2,
// and one with dwell 1 / no blanking.
module tb_demux_scan_sequencer;

   logic        clk = 1'b0;
   logic        rst, enable, load_valid;
   logic [15:0] frame_data;
   logic        load_ready, data_out, frame_done, busy;
   logic [3:0]  sel_out;

   logic        rst_b, enable_b, load_valid_b;
   logic [15:0] frame_data_b;
   logic        load_ready_b, data_out_b, frame_done_b, busy_b;
   logic [3:0]  sel_out_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   demux_scan_sequencer #(.CLK_DIV(4), .BLANK_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .enable(enable), .load_valid(load_valid),
      .load_ready(load_ready), .frame_data(frame_data), .sel_out(sel_out),
      .data_out(data_out), .frame_done(frame_done), .busy(busy)
   );

   demux_scan_sequencer #(.CLK_DIV(1), .BLANK_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst_b), .enable(enable_b), .load_valid(load_valid_b),
      .load_ready(load_ready_b), .frame_data(frame_data_b), .sel_out(sel_out_b),
      .data_out(data_out_b), .frame_done(frame_done_b), .busy(busy_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected {sel, data, frame_done} for cycle c (1..96) of a 6-cycle-per-channel frame.
   function automatic logic [5:0] exp_vec(input int c, input logic [15:0] f);
      int ch, pos;
      logic bit_v;
      ch    = (c - 1) / 6;
      pos   = (c - 1) % 6;
      bit_v = (pos >= 2) ? f[15 - ch] : 1'b0;
      return {4'(ch), bit_v, (c == 96)};
   endfunction

   task automatic do_reset();
      rst        = 1'b1;
      enable     = 1'b0;
      load_valid = 1'b0;
      frame_data = '0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic do_load(input logic [15:0] f);
      load_valid = 1'b1;
      frame_data = f;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({sel_out, data_out, frame_done, busy, load_ready} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state got sel=%0d d=%b fd=%b busy=%b rdy=%b exp sel=0 d=0 fd=0 busy=0 rdy=1",
                  sel_out, data_out, frame_done, busy, load_ready);
      end
   endtask

   task automatic test_basic_frame();
      logic [5:0] exp;
      do_reset();
      do_load(16'h8001);
      checks++;
      if (load_ready !== 1'b0) begin
         failures++;
         $display("FAIL basic_ready_after_load got %b exp 0", load_ready);
      end
      enable = 1'b1;
      tick();
      for (int c = 1; c <= 96; c++) begin
         exp = exp_vec(c, 16'h8001);
         checks++;
         if ({sel_out, data_out, frame_done, busy} !== {exp, 1'b1}) begin
            failures++;
            $display("FAIL basic_frame c=%0d got sel=%0d d=%b fd=%b busy=%b exp sel=%0d d=%b fd=%b busy=1",
                     c, sel_out, data_out, frame_done, busy, exp[5:2], exp[1], exp[0]);
         end
         tick();
      end
      enable = 1'b0;
   endtask

   task automatic test_midframe_load();
      logic [5:0] exp;
      logic       exp_rdy;
      do_reset();
      do_load(16'h0000);
      enable = 1'b1;
      tick();
      for (int c = 1; c <= 96; c++) begin
         exp     = exp_vec(c, 16'h0000);
         exp_rdy = (c <= 20);
         checks++;
         if ({sel_out, data_out, frame_done, load_ready} !== {exp, exp_rdy}) begin
            failures++;
            $display("FAIL midload_old_frame c=%0d got sel=%0d d=%b fd=%b rdy=%b exp sel=%0d d=%b fd=%b rdy=%b",
                     c, sel_out, data_out, frame_done, load_ready, exp[5:2], exp[1], exp[0], exp_rdy);
         end
         if (c == 20) begin
            load_valid = 1'b1;
            frame_data = 16'hFFFF;
         end
         tick();
         load_valid = 1'b0;
      end
      for (int c = 1; c <= 96; c++) begin
         exp = exp_vec(c, 16'hFFFF);
         checks++;
         if ({sel_out, data_out, frame_done, load_ready} !== {exp, 1'b1}) begin
            failures++;
            $display("FAIL midload_new_frame c=%0d got sel=%0d d=%b fd=%b rdy=%b exp sel=%0d d=%b fd=%b rdy=1",
                     c, sel_out, data_out, frame_done, load_ready, exp[5:2], exp[1], exp[0]);
         end
         tick();
      end
      enable = 1'b0;
   endtask

   task automatic test_pending_reject();
      logic [5:0] exp;
      do_reset();
      do_load(16'h8001);
      do_load(16'h7FFE);
      checks++;
      if (load_ready !== 1'b0) begin
         failures++;
         $display("FAIL reject_ready got %b exp 0", load_ready);
      end
      enable = 1'b1;
      tick();
      for (int c = 1; c <= 96; c++) begin
         exp = exp_vec(c, 16'h8001);
         checks++;
         if ({sel_out, data_out, frame_done} !== exp) begin
            failures++;
            $display("FAIL reject_frame c=%0d got sel=%0d d=%b fd=%b exp sel=%0d d=%b fd=%b",
                     c, sel_out, data_out, frame_done, exp[5:2], exp[1], exp[0]);
         end
         tick();
      end
      enable = 1'b0;
   endtask

   task automatic test_enable_drop();
      logic [5:0] exp;
      logic       exp_busy;
      do_reset();
      do_load(16'hFFFF);
      enable = 1'b1;
      tick();
      for (int c = 1; c <= 45; c++) begin
         if (c <= 36) begin
            exp      = exp_vec(c, 16'hFFFF);
            exp_busy = 1'b1;
         end else begin
            exp      = 6'd0;
            exp_busy = 1'b0;
         end
         checks++;
         if ({sel_out, data_out, frame_done, busy} !== {exp, exp_busy}) begin
            failures++;
            $display("FAIL enable_drop c=%0d got sel=%0d d=%b fd=%b busy=%b exp sel=%0d d=%b fd=%b busy=%b",
                     c, sel_out, data_out, frame_done, busy, exp[5:2], exp[1], exp[0], exp_busy);
         end
         if (c == 34) enable = 1'b0;
         tick();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      do_load(16'hFFFF);
      enable = 1'b1;
      tick();
      for (int c = 1; c <= 57; c++) tick();
      checks++;
      if ({sel_out, data_out, busy} !== {4'd9, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL pre_reset_drive got sel=%0d d=%b busy=%b exp sel=9 d=1 busy=1", sel_out, data_out, busy);
      end
      #1;
      enable = 1'b0;
      rst    = 1'b1;
      #1;
      checks++;
      if ({sel_out, data_out, frame_done, busy, load_ready} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL async_reset got sel=%0d d=%b fd=%b busy=%b rdy=%b exp sel=0 d=0 fd=0 busy=0 rdy=1",
                  sel_out, data_out, frame_done, busy, load_ready);
      end
      #1;
      rst = 1'b0;
      tick();
      checks++;
      if ({sel_out, data_out, busy, load_ready} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL post_reset_idle got sel=%0d d=%b busy=%b rdy=%b exp sel=0 d=0 busy=0 rdy=1",
                  sel_out, data_out, busy, load_ready);
      end
   endtask

   task automatic test_no_blank();
      logic [3:0] exp_sel;
      logic       exp_d, exp_fd;
      rst_b        = 1'b1;
      enable_b     = 1'b0;
      load_valid_b = 1'b0;
      frame_data_b = '0;
      tick();
      rst_b = 1'b0;
      tick();
      load_valid_b = 1'b1;
      frame_data_b = 16'hAAAA;
      tick();
      load_valid_b = 1'b0;
      enable_b     = 1'b1;
      tick();
      for (int c = 1; c <= 48; c++) begin
         exp_sel = 4'((c - 1) % 16);
         exp_d   = (c % 2) == 1;
         exp_fd  = (c % 16) == 0;
         checks++;
         if ({sel_out_b, data_out_b, frame_done_b, busy_b} !== {exp_sel, exp_d, exp_fd, 1'b1}) begin
            failures++;
            $display("FAIL no_blank c=%0d got sel=%0d d=%b fd=%b busy=%b exp sel=%0d d=%b fd=%b busy=1",
                     c, sel_out_b, data_out_b, frame_done_b, busy_b, exp_sel, exp_d, exp_fd);
         end
         tick();
      end
      enable_b = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      rst_b        = 1'b1;
      enable       = 1'b0;
      enable_b     = 1'b0;
      load_valid   = 1'b0;
      load_valid_b = 1'b0;
      frame_data   = '0;
      frame_data_b = '0;
      test_reset();
      test_basic_frame();
      test_midframe_load();
      test_pending_reject();
      test_enable_drop();
      test_async_reset();
      test_no_blank();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
